// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, issues one read per instruction,
// hands the result to decode and waits for the resolved next PC.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  output logic        ifu_send_valid,
  input  logic        ifu_receive_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {BOOT, AR, R, SEND, WAIT} state_t;

  state_t state;
  state_t state_nxt;
  logic   misaligned;

  // A PC with nonzero low bits is never put on the bus; it becomes an ebreak.
  assign misaligned = (pc[1:0] != 2'b00);
  assign araddr     = pc;

  // State register; a low rst at a rising edge returns to BOOT.
  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  // Next-state logic and handshake outputs decoded purely from registered state.
  always_comb begin
    state_nxt      = state;
    arvalid        = 1'b0;
    rready         = 1'b0;
    ifu_send_valid = 1'b0;
    case (state)
      BOOT: state_nxt = AR;
      AR: begin
        if (misaligned) begin
          state_nxt = SEND;
        end else begin
          arvalid = 1'b1;
          if (arready) state_nxt = R;
        end
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = SEND;
      end
      SEND: begin
        ifu_send_valid = 1'b1;
        if (ifu_receive_ready) state_nxt = pc_write_enable ? AR : WAIT;
      end
      WAIT: begin
        if (pc_write_enable) state_nxt = AR;
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Architectural registers: PC, captured instruction, sticky error, accept counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instruction <= 32'h0;
      fetch_error <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        AR: begin
          if (misaligned) begin
            instruction <= EBREAK;
            fetch_error <= 1'b1;
          end
        end
        R: begin
          if (rvalid) begin
            if (rresp == 2'b00) begin
              instruction <= rdata;
            end else begin
              instruction <= EBREAK;
              fetch_error <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ifu_receive_ready) begin
            fetch_count <= fetch_count + 32'd1;
            if (pc_write_enable) pc <= pc_next;
          end
        end
        WAIT: begin
          if (pc_write_enable) pc <= pc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: directed bus/decode stimulus with a scoreboard monitor.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pc_next;
  logic        pc_write_enable;
  logic        ifu_send_valid;
  logic        ifu_receive_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_error;
  logic [31:0] fetch_count;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .pc_next(pc_next), .pc_write_enable(pc_write_enable),
    .ifu_send_valid(ifu_send_valid), .ifu_receive_ready(ifu_receive_ready),
    .instruction(instruction), .pc(pc),
    .fetch_error(fetch_error), .fetch_count(fetch_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks    = 0;
  int          errors    = 0;
  int          ar_count  = 0;
  logic [31:0] exp_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts address handshakes and scores every instruction decode accepts.
  always @(negedge clk) begin
    if (arvalid && arready) ar_count++;
    if (ifu_send_valid && ifu_receive_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: instruction %h pc %h delivered with nothing expected", instruction, pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_instruction", instruction, mon_e.instr);
        chk("mon_pc", pc, mon_e.addr);
        chk("mon_fetch_error", {31'b0, fetch_error}, {31'b0, mon_e.err});
      end
    end
  end

  // Memory side of one aligned fetch; entered and left at posedge+1.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input int arw, input int rw, input logic err);
    int n = 0;
    while (!arvalid && n < 30) begin @(posedge clk); #1; n++; end
    if (!arvalid) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arvalid still 0 after %0d cycles, required 1", n);
      return;
    end
    chk("fetch_araddr", araddr, addr);
    exp_q.push_back('{instr: (resp == 2'b00) ? data : EBREAK, addr: addr, err: err});
    repeat (arw) begin
      pc_write_enable = 1'b1;
      pc_next = 32'hDEAD_BEE0;
      @(posedge clk); #1;
      chk("ar_hold_valid", {31'b0, arvalid}, 32'd1);
      chk("ar_hold_addr", araddr, addr);
    end
    pc_write_enable = 1'b0;
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    repeat (rw) begin
      chk("r_hold_rready", {31'b0, rready}, 32'd1);
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = data; rresp = resp;
    @(posedge clk); #1;
    rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
  endtask

  // Decode side: wait w cycles, accept, then redirect (same cycle or after gap).
  task automatic do_accept(input int w, input logic same, input logic [31:0] pcn, input int gap);
    int n = 0;
    while (!ifu_send_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (!ifu_send_valid) begin
      checks++; errors++;
      $display("FAIL send_timeout: ifu_send_valid still 0 after %0d cycles, required 1", n);
      return;
    end
    repeat (w) begin
      @(posedge clk); #1;
      chk("send_hold_valid", {31'b0, ifu_send_valid}, 32'd1);
      if (exp_q.size() > 0) begin
        chk("send_hold_instruction", instruction, exp_q[0].instr);
        chk("send_hold_pc", pc, exp_q[0].addr);
      end
    end
    ifu_receive_ready = 1'b1;
    if (same) begin pc_write_enable = 1'b1; pc_next = pcn; end
    @(posedge clk); #1;
    ifu_receive_ready = 1'b0;
    pc_write_enable = 1'b0;
    exp_count++;
    chk("fetch_count", fetch_count, exp_count);
    if (same) begin
      chk("redirect_pc", pc, pcn);
      chk("redirect_arvalid", {31'b0, arvalid}, {31'b0, (pcn[1:0] == 2'b00)});
      chk("redirect_no_send", {31'b0, ifu_send_valid}, 32'd0);
    end else begin
      chk("wait_idle", {29'b0, arvalid, rready, ifu_send_valid}, 32'd0);
      repeat (gap) begin @(posedge clk); #1; end
      pc_write_enable = 1'b1; pc_next = pcn;
      @(posedge clk); #1;
      pc_write_enable = 1'b0;
      chk("wait_pc", pc, pcn);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar_before;
    rst = 1'b0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
    pc_next = 32'h0; pc_write_enable = 1'b0; ifu_receive_ready = 1'b0;

    // Reset and boot
    repeat (3) @(posedge clk);
    #1;
    chk("rst_handshakes", {29'b0, arvalid, rready, ifu_send_valid}, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_fetch_error", {31'b0, fetch_error}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("boot_arvalid", {31'b0, arvalid}, 32'd0);
    @(posedge clk); #1;
    chk("first_arvalid", {31'b0, arvalid}, 32'd1);
    chk("first_araddr", araddr, 32'h8000_0000);

    // Zero-wait fetch
    exp_q.push_back('{instr: 32'h0000_0513, addr: 32'h8000_0000, err: 1'b0});
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("zw_rready", {31'b0, rready}, 32'd1);
    chk("zw_no_send_yet", {31'b0, ifu_send_valid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0000_0513;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("zw_send_valid", {31'b0, ifu_send_valid}, 32'd1);
    chk("zw_instruction", instruction, 32'h0000_0513);
    do_accept(0, 1'b0, 32'h8000_0004, 0);
    chk("zw_next_araddr", araddr, 32'h8000_0004);
    chk("zw_next_arvalid", {31'b0, arvalid}, 32'd1);

    // Backpressure: slow memory and slow decode
    ar_before = ar_count;
    do_fetch(32'h8000_0004, 32'h00A0_0093, 2'b00, 3, 5, 1'b0);
    do_accept(4, 1'b0, 32'h8000_0008, 1);
    chk("bp_one_fetch", ar_count - ar_before, 32'd1);

    // Simultaneous accept and redirect
    do_fetch(32'h8000_0008, 32'h00B0_0113, 2'b00, 0, 0, 1'b0);
    do_accept(0, 1'b1, 32'h8000_0100, 0);

    // Error response
    do_fetch(32'h8000_0100, 32'h1234_5678, 2'b10, 0, 0, 1'b1);
    do_accept(0, 1'b0, 32'h8000_0002, 0);

    // Misaligned PC: no bus request, ebreak delivered
    ar_before = ar_count;
    chk("mis_no_arvalid", {31'b0, arvalid}, 32'd0);
    exp_q.push_back('{instr: EBREAK, addr: 32'h8000_0002, err: 1'b1});
    @(posedge clk); #1;
    chk("mis_send_valid", {31'b0, ifu_send_valid}, 32'd1);
    chk("mis_instruction", instruction, EBREAK);
    do_accept(0, 1'b0, 32'h8000_0200, 0);
    chk("mis_no_bus_read", ar_count - ar_before, 32'd0);

    // Ten more fetches; the error flag stays sticky
    for (int i = 0; i < 10; i++) begin
      do_fetch(32'h8000_0200 + 32'(4 * i), 32'h0010_0093 + 32'(i), 2'b00, 0, 0, 1'b1);
      do_accept(0, 1'b0, 32'h8000_0204 + 32'(4 * i), 0);
    end
    chk("sticky_fetch_error", {31'b0, fetch_error}, 32'd1);
    chk("count_before_reset", fetch_count, 32'd15);

    // Reset while a read is in flight
    chk("pre_rst_arvalid", {31'b0, arvalid}, 32'd1);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("pre_rst_rready", {31'b0, rready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    chk("mid_rst_rready", {31'b0, rready}, 32'd0);
    chk("mid_rst_arvalid", {31'b0, arvalid}, 32'd0);
    chk("mid_rst_instruction", instruction, 32'h0);
    chk("mid_rst_pc", pc, RESET_PC);
    chk("mid_rst_fetch_count", fetch_count, 32'd0);
    chk("mid_rst_fetch_error", {31'b0, fetch_error}, 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h0;
    chk("late_rvalid_ignored", instruction, 32'h0);
    chk("restart_arvalid", {31'b0, arvalid}, 32'd1);
    chk("restart_araddr", araddr, RESET_PC);
    exp_count = 0;
    do_fetch(RESET_PC, 32'h0000_0297, 2'b00, 0, 0, 1'b0);
    do_accept(0, 1'b0, RESET_PC + 32'd4, 0);

    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
